// File: rtl/uart_tx_word.sv
// uart_tx_word: serializes a WIDTH-bit word LSB first with one start bit and one stop bit
module uart_tx_word #(
    parameter int WIDTH  = 64,
    parameter int CLKDIV = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             ld_tx_data,
    output logic             tx_out,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx_overrun,
    output logic [7:0]       overrun_count
);
    localparam int CW = $clog2(CLKDIV + 1);
    localparam int IW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_shift, w_shift_nx;
    logic [CW-1:0]    r_cnt, w_cnt_nx;
    logic [IW-1:0]    r_idx, w_idx_nx;
    logic             r_tx, w_tx_nx;
    logic             r_busy, w_busy_nx;
    logic             r_done, w_done_nx;
    logic             r_ovr, w_ovr_nx;
    logic [7:0]       r_ovr_cnt, w_ovr_cnt_nx;
    logic             w_period_end;
    assign w_period_end  = r_cnt == CW'(CLKDIV - 1);
    assign tx_out        = r_tx;
    assign tx_busy       = r_busy;
    assign tx_done       = r_done;
    assign tx_overrun    = r_ovr;
    assign overrun_count = r_ovr_cnt;
    // Next frame state, serial bit and overrun bookkeeping; every output is registered from these
    always_comb begin
        w_state_nx   = r_state;
        w_shift_nx   = r_shift;
        w_cnt_nx     = w_period_end ? '0 : r_cnt + CW'(1);
        w_idx_nx     = r_idx;
        w_tx_nx      = r_tx;
        w_busy_nx    = r_busy;
        w_done_nx    = 1'b0;
        w_ovr_nx     = ld_tx_data && r_busy;
        w_ovr_cnt_nx = (w_ovr_nx && r_ovr_cnt != 8'hFF) ? r_ovr_cnt + 8'd1 : r_ovr_cnt;
        case (r_state)
            IDLE: begin
                w_cnt_nx = '0;
                if (ld_tx_data) begin
                    w_state_nx = START;
                    w_shift_nx = tx_data;
                    w_tx_nx    = 1'b0;
                    w_busy_nx  = 1'b1;
                end
            end
            START: begin
                if (w_period_end) begin
                    w_state_nx = DATA;
                    w_tx_nx    = r_shift[0];
                    w_shift_nx = r_shift >> 1;
                    w_idx_nx   = '0;
                end
            end
            DATA: begin
                if (w_period_end) begin
                    if (r_idx == IW'(WIDTH - 1)) begin
                        w_state_nx = STOP;
                        w_tx_nx    = 1'b1;
                    end else begin
                        w_tx_nx    = r_shift[0];
                        w_shift_nx = r_shift >> 1;
                        w_idx_nx   = r_idx + IW'(1);
                    end
                end
            end
            STOP: begin
                if (w_period_end) begin
                    w_state_nx = IDLE;
                    w_busy_nx  = 1'b0;
                    w_done_nx  = 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end
    // State register; reset aborts any frame in flight and returns the line to idle-high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovr     <= 1'b0;
            r_ovr_cnt <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_shift   <= w_shift_nx;
            r_cnt     <= w_cnt_nx;
            r_idx     <= w_idx_nx;
            r_tx      <= w_tx_nx;
            r_busy    <= w_busy_nx;
            r_done    <= w_done_nx;
            r_ovr     <= w_ovr_nx;
            r_ovr_cnt <= w_ovr_cnt_nx;
        end
    end
endmodule
